rob_commit_ctrl: RTL and testbench
==================================

Name: rob_commit_ctrl

Overview:
In-order allocation and retirement scheduler that owns the rename/commit interface of the register file. It hands out ROB tags to dispatch and drives the RF "new" (rename) port. It tracks completion from the CDB, retires one entry per cycle into the RF "write" port, and raises jump_wrong on retirement of a mispredicted control-flow entry. It also serves tag-based operand forwarding to dispatch.

Parameters:
ROB_IDX_W, 4, tag width; must match the codebase `ROB_INDEX_RANGE` width.
DEPTH, 16, number of entries; always 2**ROB_IDX_W.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
rdy  in  1  global enable; low = freeze all state
alloc_valid_in  in  1  dispatch requests an entry
alloc_rd_in  in  5  destination register of the request
alloc_ready_out  out  1  entry available this cycle
alloc_idx_out  out  ROB_IDX_W  tag given to the request (= tail)
cdb_valid_in  in  1  completion broadcast
cdb_idx_in  in  ROB_IDX_W  completing tag
cdb_val_in  in  32  result value
cdb_mispred_in  in  1  completing entry was mispredicted
cdb_pc_in  in  32  correct target PC (used only when mispredicted)
qry1_idx_in, qry2_idx_in  in  ROB_IDX_W  operand tags (from RF rs1/rs2 idx)
qry1_ready_out, qry2_ready_out  out  1  value for tag available
qry1_val_out, qry2_val_out  out  32  forwarded value
rf_new_flag_out  out  1  rename strobe to RF
rf_new_idx_out  out  ROB_IDX_W  = alloc_idx_out
rf_new_rd_out  out  5  = alloc_rd_in
rf_write_flag_out  out  1  commit strobe to RF
rf_write_idx_out  out  ROB_IDX_W  head tag
rf_write_rd_out  out  5  head rd
rf_val_out  out  32  head value
jump_wrong_out  out  1  flush pulse to the whole core
jump_pc_out  out  32  redirect PC, valid with jump_wrong_out

Behaviour:
- Per-entry state: busy, done, mispred, rd[4:0], val[31:0], pc[31:0]. Controller state: head, tail, count (ROB_IDX_W+1 bits), FSM {RUN, FLUSH}.
- Reset (rst_n low, async): head = tail = count = 0; all busy/done = 0; FSM = RUN; every output 0 except alloc_idx_out = 0, and alloc_ready_out = 1 after release.
- rdy low: no state change. rf_new_flag_out, rf_write_flag_out and jump_wrong_out are forced 0.
- Allocation:
  - alloc_ready_out = (FSM == RUN) && (count < DEPTH).
  - accept = rdy && alloc_valid_in && alloc_ready_out.
  - rf_new_flag_out = accept, combinational in the same cycle; the RF latches it at the same edge.
  - At the edge: entry[tail] gets busy = 1, done = 0, mispred = 0, rd = alloc_rd_in; tail increments modulo DEPTH.
  - rd = 0 is allocated normally; the RF ignores it.
- Completion: on cdb_valid_in, if entry[cdb_idx_in] is busy, set done = 1, val = cdb_val_in, mispred = cdb_mispred_in, pc = cdb_pc_in. A CDB to a non-busy tag is ignored.
- Commit:
  - commit = rdy && FSM == RUN && count != 0 && busy[head] && done[head]. Readiness is the registered done bit, so a CDB to the head commits no earlier than the next cycle.
  - rf_write_* are combinational from the head entry, with flag = commit.
  - At the edge: clear busy[head]; head increments modulo DEPTH. count changes by accept − commit; both may occur in the same cycle.
- Mispredict:
  - If the committing entry has mispred = 1, its RF write still occurs in that cycle N (link register preserved).
  - At the edge: FSM -> FLUSH; jump_pc_out is registered from pc.
- FLUSH state (exactly one cycle, N+1):
  - jump_wrong_out = 1; no accept, no commit; CDB input ignored.
  - At the edge: all busy/done cleared, head = tail = count = 0, FSM -> RUN.
  - jump_wrong_out is 0 in every other cycle.
- Forwarding, per query k:
  - qryk_ready_out = done[idx] || (cdb_valid_in && cdb_idx_in == idx). CDB takes priority on value.
  - Purely combinational.

Decomposition:
- Shared package/define file: ROB_IDX_W, DEPTH, REG_IDX_W = 5, and FSM state encodings.
- One natural sub-module: rob_entry_bank (entry storage, CDB write, two forwarding read ports), instanced by rob_commit_ctrl, which keeps pointers, count and the FSM.

Test Plan:
- Reset, then allocate rd = 5, 6, 7 -> tags 0, 1, 2; rf_new_flag_out high each cycle; count = 3.
- CDB tag 1 (val 0x11) then tag 0 (val 0x22) -> commits: tag 0 rd 5 val 0x22, then tag 1 rd 6 val 0x11, one per cycle, in order.
- Fill 16 entries -> alloc_ready_out = 0; complete and commit the head while alloc_valid_in is held -> tag 0 is reused one cycle after the commit; tail wraps 15 -> 0.
- CDB tag 2 mispred = 1, pc 0x100, entries 3–5 busy -> commit rd write at cycle N; cycle N+1 jump_wrong_out = 1, jump_pc_out = 0x100, alloc_ready_out = 0; cycle N+2 count = 0, head = tail = 0.
- qry1_idx_in = 3 with cdb_valid_in on tag 3, val 0xABCD, in the same cycle -> qry1_ready_out = 1, qry1_val_out = 0xABCD combinationally.
- Hold rdy = 0 with alloc_valid_in and a ready head -> no strobes, pointers unchanged; assert rst_n low mid-FLUSH -> all outputs 0 immediately.

Source files
------------

// File: rtl/rob_commit_ctrl_pkg.sv
// Shared sizing constants and controller state type for the ROB commit controller.
package rob_commit_ctrl_pkg;
  localparam int unsigned ROB_IDX_W = 4;
  localparam int unsigned DEPTH     = 2 ** ROB_IDX_W;
  localparam int unsigned REG_IDX_W = 5;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } rob_state_e;
endpackage

// File: rtl/rob_commit_ctrl_entry_bank.sv
// ROB entry storage: allocation/CDB/commit/flush updates, head read port and
// two tag-forwarding read ports.
module rob_entry_bank
  import rob_commit_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned NENT  = 2 ** IDX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 alloc_we_i,
  input  logic [IDX_W-1:0]     alloc_idx_i,
  input  logic [REG_IDX_W-1:0] alloc_rd_i,
  input  logic                 cdb_we_i,
  input  logic                 cdb_fwd_i,
  input  logic [IDX_W-1:0]     cdb_idx_i,
  input  logic [31:0]          cdb_val_i,
  input  logic                 cdb_mispred_i,
  input  logic [31:0]          cdb_pc_i,
  input  logic                 commit_i,
  input  logic [IDX_W-1:0]     head_idx_i,
  output logic                 head_busy_o,
  output logic                 head_done_o,
  output logic                 head_mispred_o,
  output logic [REG_IDX_W-1:0] head_rd_o,
  output logic [31:0]          head_val_o,
  output logic [31:0]          head_pc_o,
  input  logic [IDX_W-1:0]     qry1_idx_i,
  output logic                 qry1_ready_o,
  output logic [31:0]          qry1_val_o,
  input  logic [IDX_W-1:0]     qry2_idx_i,
  output logic                 qry2_ready_o,
  output logic [31:0]          qry2_val_o
);
  logic [NENT-1:0]      busy_q, done_q, mis_q;
  logic [REG_IDX_W-1:0] rd_q  [NENT];
  logic [31:0]          val_q [NENT];
  logic [31:0]          pc_q  [NENT];
  logic                 hit1, hit2;

  // Payload is reset too so the head read port shows zeros out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      done_q <= '0;
      mis_q  <= '0;
      for (int unsigned i = 0; i < NENT; i++) begin
        rd_q[i]  <= '0;
        val_q[i] <= '0;
        pc_q[i]  <= '0;
      end
    end else if (flush_i) begin
      busy_q <= '0;
      done_q <= '0;
    end else begin
      if (commit_i) busy_q[head_idx_i] <= 1'b0;
      if (cdb_we_i && busy_q[cdb_idx_i]) begin
        done_q[cdb_idx_i] <= 1'b1;
        mis_q[cdb_idx_i]  <= cdb_mispred_i;
        val_q[cdb_idx_i]  <= cdb_val_i;
        pc_q[cdb_idx_i]   <= cdb_pc_i;
      end
      if (alloc_we_i) begin
        busy_q[alloc_idx_i] <= 1'b1;
        done_q[alloc_idx_i] <= 1'b0;
        mis_q[alloc_idx_i]  <= 1'b0;
        rd_q[alloc_idx_i]   <= alloc_rd_i;
      end
    end
  end

  assign head_busy_o    = busy_q[head_idx_i];
  assign head_done_o    = done_q[head_idx_i];
  assign head_mispred_o = mis_q[head_idx_i];
  assign head_rd_o      = rd_q[head_idx_i];
  assign head_val_o     = val_q[head_idx_i];
  assign head_pc_o      = pc_q[head_idx_i];

  assign hit1         = cdb_fwd_i && (cdb_idx_i == qry1_idx_i);
  assign hit2         = cdb_fwd_i && (cdb_idx_i == qry2_idx_i);
  assign qry1_ready_o = done_q[qry1_idx_i] || hit1;
  assign qry2_ready_o = done_q[qry2_idx_i] || hit2;
  assign qry1_val_o   = hit1 ? cdb_val_i : val_q[qry1_idx_i];
  assign qry2_val_o   = hit2 ? cdb_val_i : val_q[qry2_idx_i];
endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order ROB allocation/retirement controller: pointers, occupancy count and
// RUN/FLUSH sequencing around the entry bank.
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
#(
  parameter int unsigned ROB_IDX_W = rob_commit_ctrl_pkg::ROB_IDX_W,
  parameter int unsigned DEPTH     = 2 ** ROB_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 alloc_valid_in,
  input  logic [REG_IDX_W-1:0] alloc_rd_in,
  output logic                 alloc_ready_out,
  output logic [ROB_IDX_W-1:0] alloc_idx_out,
  input  logic                 cdb_valid_in,
  input  logic [ROB_IDX_W-1:0] cdb_idx_in,
  input  logic [31:0]          cdb_val_in,
  input  logic                 cdb_mispred_in,
  input  logic [31:0]          cdb_pc_in,
  input  logic [ROB_IDX_W-1:0] qry1_idx_in,
  input  logic [ROB_IDX_W-1:0] qry2_idx_in,
  output logic                 qry1_ready_out,
  output logic                 qry2_ready_out,
  output logic [31:0]          qry1_val_out,
  output logic [31:0]          qry2_val_out,
  output logic                 rf_new_flag_out,
  output logic [ROB_IDX_W-1:0] rf_new_idx_out,
  output logic [REG_IDX_W-1:0] rf_new_rd_out,
  output logic                 rf_write_flag_out,
  output logic [ROB_IDX_W-1:0] rf_write_idx_out,
  output logic [REG_IDX_W-1:0] rf_write_rd_out,
  output logic [31:0]          rf_val_out,
  output logic                 jump_wrong_out,
  output logic [31:0]          jump_pc_out
);
  localparam int unsigned CW = ROB_IDX_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  rob_state_e           state_q, state_d;
  logic [ROB_IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic [31:0]          jump_pc_q, jump_pc_d;

  logic        alloc_ready, accept, commit, in_run, flush;
  logic        head_busy, head_done, head_mispred;
  logic [31:0] head_pc;

  assign in_run = (state_q == ST_RUN);
  // Gated by rst_n so ready reads 0 while reset is held and 1 right after release.
  assign alloc_ready = rst_n && in_run && (count_q < DEPTH_C);
  assign accept      = rdy && alloc_valid_in && alloc_ready;
  assign commit      = rdy && in_run && (count_q != '0) && head_busy && head_done;
  assign flush       = rdy && (state_q == ST_FLUSH);

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    jump_pc_d = jump_pc_q;
    if (rdy) begin
      case (state_q)
        ST_RUN: begin
          if (accept) tail_d = tail_q + ROB_IDX_W'(1);
          if (commit) begin
            head_d = head_q + ROB_IDX_W'(1);
            if (head_mispred) begin
              state_d   = ST_FLUSH;
              jump_pc_d = head_pc;
            end
          end
          count_d = count_q + CW'(accept) - CW'(commit);
        end
        ST_FLUSH: begin
          head_d  = '0;
          tail_d  = '0;
          count_d = '0;
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      jump_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      jump_pc_q <= jump_pc_d;
    end
  end

  rob_entry_bank #(
    .IDX_W (ROB_IDX_W),
    .NENT  (DEPTH)
  ) u_bank (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush),
    .alloc_we_i     (accept),
    .alloc_idx_i    (tail_q),
    .alloc_rd_i     (alloc_rd_in),
    .cdb_we_i       (rdy && in_run && cdb_valid_in),
    .cdb_fwd_i      (cdb_valid_in),
    .cdb_idx_i      (cdb_idx_in),
    .cdb_val_i      (cdb_val_in),
    .cdb_mispred_i  (cdb_mispred_in),
    .cdb_pc_i       (cdb_pc_in),
    .commit_i       (commit),
    .head_idx_i     (head_q),
    .head_busy_o    (head_busy),
    .head_done_o    (head_done),
    .head_mispred_o (head_mispred),
    .head_rd_o      (rf_write_rd_out),
    .head_val_o     (rf_val_out),
    .head_pc_o      (head_pc),
    .qry1_idx_i     (qry1_idx_in),
    .qry1_ready_o   (qry1_ready_out),
    .qry1_val_o     (qry1_val_out),
    .qry2_idx_i     (qry2_idx_in),
    .qry2_ready_o   (qry2_ready_out),
    .qry2_val_o     (qry2_val_out)
  );

  assign alloc_ready_out   = alloc_ready;
  assign alloc_idx_out     = tail_q;
  assign rf_new_flag_out   = accept;
  assign rf_new_idx_out    = tail_q;
  assign rf_new_rd_out     = alloc_rd_in;
  assign rf_write_flag_out = commit;
  assign rf_write_idx_out  = head_q;
  assign jump_wrong_out    = flush;
  assign jump_pc_out       = jump_pc_q;
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Randomised + directed bench for rob_commit_ctrl against a queue-based ROB model.
module tb_rob_commit_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rdy, alloc_valid_in, cdb_valid_in, cdb_mispred_in;
  logic [4:0]  alloc_rd_in;
  logic [3:0]  cdb_idx_in, qry1_idx_in, qry2_idx_in;
  logic [31:0] cdb_val_in, cdb_pc_in;
  logic        alloc_ready_out, qry1_ready_out, qry2_ready_out;
  logic        rf_new_flag_out, rf_write_flag_out, jump_wrong_out;
  logic [3:0]  alloc_idx_out, rf_new_idx_out, rf_write_idx_out;
  logic [4:0]  rf_new_rd_out, rf_write_rd_out;
  logic [31:0] qry1_val_out, qry2_val_out, rf_val_out, jump_pc_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: program-ordered queue of live tags plus per-tag results.
  int          mq[$];
  int          m_tail;
  bit          m_done[16];
  bit          m_mis[16];
  logic [4:0]  m_rd[16];
  logic [31:0] m_val[16];
  logic [31:0] m_pc[16];
  bit          m_flush;
  logic [31:0] m_jpc;

  rob_commit_ctrl #(.ROB_IDX_W(4), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .alloc_valid_in(alloc_valid_in), .alloc_rd_in(alloc_rd_in),
    .alloc_ready_out(alloc_ready_out), .alloc_idx_out(alloc_idx_out),
    .cdb_valid_in(cdb_valid_in), .cdb_idx_in(cdb_idx_in), .cdb_val_in(cdb_val_in),
    .cdb_mispred_in(cdb_mispred_in), .cdb_pc_in(cdb_pc_in),
    .qry1_idx_in(qry1_idx_in), .qry2_idx_in(qry2_idx_in),
    .qry1_ready_out(qry1_ready_out), .qry2_ready_out(qry2_ready_out),
    .qry1_val_out(qry1_val_out), .qry2_val_out(qry2_val_out),
    .rf_new_flag_out(rf_new_flag_out), .rf_new_idx_out(rf_new_idx_out),
    .rf_new_rd_out(rf_new_rd_out), .rf_write_flag_out(rf_write_flag_out),
    .rf_write_idx_out(rf_write_idx_out), .rf_write_rd_out(rf_write_rd_out),
    .rf_val_out(rf_val_out), .jump_wrong_out(jump_wrong_out), .jump_pc_out(jump_pc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_busy(input int t);
    foreach (mq[i]) if (mq[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_clear();
    mq.delete();
    m_tail  = 0;
    m_flush = 1'b0;
    for (int i = 0; i < 16; i++) m_done[i] = 1'b0;
  endfunction

  task automatic check_query(input string tag, input int idx, input bit rdy_o, input logic [31:0] val_o);
    bit hit;
    hit = cdb_valid_in && (int'(cdb_idx_in) == idx);
    check(tag, rdy_o, m_done[idx] || hit);
    if (m_done[idx] || hit) check({tag, "_val"}, val_o, hit ? cdb_val_in : m_val[idx]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rdy = 1'b0; alloc_valid_in = 1'b0; alloc_rd_in = '0;
    cdb_valid_in = 1'b0; cdb_idx_in = '0; cdb_val_in = '0; cdb_mispred_in = 1'b0; cdb_pc_in = '0;
    qry1_idx_in = '0; qry2_idx_in = '0;
    #1;
    check("rst_alloc_ready", alloc_ready_out, 0);
    check("rst_alloc_idx", alloc_idx_out, 0);
    check("rst_new_flag", rf_new_flag_out, 0);
    check("rst_write_flag", rf_write_flag_out, 0);
    check("rst_write_rd", rf_write_rd_out, 0);
    check("rst_write_val", rf_val_out, 0);
    check("rst_jump_wrong", jump_wrong_out, 0);
    check("rst_jump_pc", jump_pc_out, 0);
    check("rst_qry1", qry1_ready_out, 0);
    check("rst_qry2_val", qry2_val_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    m_jpc = '0;
    for (int i = 0; i < 16; i++) begin
      m_val[i] = '0; m_rd[i] = '0; m_pc[i] = '0; m_mis[i] = 1'b0;
    end
  endtask

  task automatic step(input bit r, input bit av, input logic [4:0] rd, input bit cv, input int ci,
                      input logic [31:0] cval, input bit cm, input logic [31:0] cpc,
                      input int q1, input int q2);
    bit ex_ready, acc, com, h_mis;
    int h;
    logic [31:0] h_pc;
    rdy = r; alloc_valid_in = av; alloc_rd_in = rd;
    cdb_valid_in = cv; cdb_idx_in = 4'(ci); cdb_val_in = cval; cdb_mispred_in = cm; cdb_pc_in = cpc;
    qry1_idx_in = 4'(q1); qry2_idx_in = 4'(q2);
    #1;
    ex_ready = !m_flush && (mq.size() < 16);
    acc = r && av && ex_ready;
    com = r && !m_flush && (mq.size() != 0) && m_done[mq.size() != 0 ? mq[0] : 0];
    check("alloc_ready", alloc_ready_out, ex_ready);
    check("alloc_idx", alloc_idx_out, m_tail);
    check("new_flag", rf_new_flag_out, acc);
    check("new_idx", rf_new_idx_out, m_tail);
    check("new_rd", rf_new_rd_out, rd);
    check("write_flag", rf_write_flag_out, com);
    if (com) begin
      check("write_idx", rf_write_idx_out, mq[0]);
      check("write_rd", rf_write_rd_out, m_rd[mq[0]]);
      check("write_val", rf_val_out, m_val[mq[0]]);
    end
    check("jump_wrong", jump_wrong_out, r && m_flush);
    if (r && m_flush) check("jump_pc", jump_pc_out, m_jpc);
    check_query("qry1", q1, qry1_ready_out, qry1_val_out);
    check_query("qry2", q2, qry2_ready_out, qry2_val_out);
    @(posedge clk);
    if (r) begin
      if (m_flush) begin
        model_clear();
      end else begin
        h = 0; h_mis = 1'b0; h_pc = '0;
        if (com) begin h = mq[0]; h_mis = m_mis[h]; h_pc = m_pc[h]; end
        if (cv && m_busy(ci)) begin
          m_done[ci] = 1'b1; m_val[ci] = cval; m_mis[ci] = cm; m_pc[ci] = cpc;
        end
        if (com) begin
          void'(mq.pop_front());
          if (h_mis) begin m_flush = 1'b1; m_jpc = h_pc; end
        end
        if (acc) begin
          mq.push_back(m_tail);
          m_done[m_tail] = 1'b0; m_mis[m_tail] = 1'b0; m_rd[m_tail] = rd;
          m_tail = (m_tail + 1) % 16;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic rand_step();
    int cand[$];
    int ci;
    foreach (mq[i]) if (!m_done[mq[i]]) cand.push_back(mq[i]);
    if (cand.size() > 0 && $urandom_range(0, 3) != 0) ci = cand[$urandom_range(0, cand.size() - 1)];
    else ci = int'($urandom_range(0, 15));
    step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6, 5'($urandom),
         $urandom_range(0, 3) != 0, ci, $urandom, $urandom_range(0, 11) == 0, $urandom,
         int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
  endtask

  initial begin
    int guard;
    #2;
    do_reset();

    // In-order commit of out-of-order completions, with a frozen cycle in between.
    step(1, 1, 5, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 6, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 7, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 1, 32'h11, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0, 32'h22, 0, 0, 0, 1);
    step(0, 1, 9, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 9, 0, 0, 0, 0, 0, 0, 1);
    idle(3);
    do_reset();

    // Full ROB, head completes while dispatch waits, tag 0 reused after wrap.
    for (int i = 0; i < 16; i++) step(1, 1, 5'(i + 1), 0, 0, 0, 0, 0, 0, 15);
    step(1, 1, 20, 1, 0, 32'h5a5a, 0, 0, 0, 15);
    step(1, 1, 21, 0, 0, 0, 0, 0, 0, 15);
    step(1, 1, 22, 0, 0, 0, 0, 0, 0, 15);
    step(1, 1, 23, 0, 0, 0, 0, 0, 0, 15);
    do_reset();

    // Mispredict on tag 2 with younger entries live, plus same-cycle CDB forwarding.
    for (int i = 0; i < 6; i++) step(1, 1, 5'(i + 1), 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 0, 32'hA0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 1, 32'hA1, 0, 0, 0, 1);
    step(1, 0, 0, 1, 2, 32'hA2, 1, 32'h100, 2, 1);
    step(1, 0, 0, 1, 3, 32'hABCD, 0, 0, 3, 2);
    step(0, 1, 4, 1, 4, 32'h44, 0, 0, 4, 3);
    step(1, 1, 4, 1, 4, 32'h44, 0, 0, 4, 3);
    idle(2);

    for (int i = 0; i < 1500; i++) rand_step();

    // Reach a FLUSH cycle and pull reset in the middle of it.
    guard = 0;
    while (!m_flush && guard < 3000) begin
      rand_step();
      guard++;
    end
    check("flush_reached", m_flush, 1);
    do_reset();
    for (int i = 0; i < 300; i++) rand_step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
